// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FWFT FIFO built from a registered-read RAM and an output register.
// Runs at one word per cycle. It provides occupancy count and registered threshold flags.
module sync_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 512,
  parameter int ALMOST_FULL  = 0,
  parameter int ALMOST_EMPTY = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_almost_full,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_almost_empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);

  if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_geom
    $error("sync_fifo: WIDTH must be >= 1 and DEPTH a power of two >= 4");
  end
  if (ALMOST_FULL >= DEPTH || ALMOST_EMPTY >= DEPTH) begin : g_bad_thr
    $error("sync_fifo: ALMOST_FULL and ALMOST_EMPTY must be below DEPTH");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_rd_data, r_out_data;
  logic             r_rd_valid, r_out_valid;
  logic [CW-1:0]    r_count;
  logic             r_in_ready, r_af, r_ae;

  logic          w_clr, w_push, w_pop, w_load, w_rd;
  logic [CW-1:0] w_count_nx;

  assign w_clr      = reset | flush;
  assign w_push     = in_valid & r_in_ready;
  assign w_pop      = r_out_valid & out_ready;
  // The read stage refills the output register whenever that register empties or pops.
  // The RAM is read whenever the read stage is free, or is being drained in the same cycle.
  assign w_load     = r_rd_valid & (~r_out_valid | w_pop);
  assign w_rd       = (r_wptr != r_rptr) & (~r_rd_valid | w_load);
  assign w_count_nx = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rd_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_af        <= DEPTH <= ALMOST_FULL;
      r_ae        <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + CW'(1);
      if (w_rd) r_rptr <= r_rptr + CW'(1);
      r_rd_valid  <= w_rd | (r_rd_valid & ~w_load);
      r_out_valid <= w_load | (r_out_valid & ~w_pop);
      r_count     <= w_count_nx;
      r_in_ready  <= w_count_nx < DEPTH_C;
      r_af        <= (DEPTH_C - w_count_nx) <= AF_C;
      r_ae        <= w_count_nx <= AE_C;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data;
    if (w_rd) r_rd_data <= r_mem[r_rptr[AW-1:0]];
    if (w_load) r_out_data <= r_rd_data;
  end

  assign in_ready         = r_in_ready;
  assign in_almost_full   = r_af;
  assign out_valid        = r_out_valid;
  assign out_data         = r_out_data;
  assign out_almost_empty = r_ae;
  assign count            = r_count;
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised-width/depth FIFO with valid/ready handshakes on both sides, programmable almost-full/almost-empty thresholds, occupancy count and synchronous flush. It succeeds the 8-bit dual-clock FIFO wherever producer and consumer share one clock, such as the UART, SPI and bus-bridge paths. It drops the gray-code synchronisers and the per-word handshake turnaround, so it sustains one word per cycle.

## Interface
- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 512, capacity in words; power of two, >= 4
- ALMOST_FULL, 0, in_almost_full asserts when free space <= ALMOST_FULL (0 = full flag)
- ALMOST_EMPTY, 0, out_almost_empty asserts when count <= ALMOST_EMPTY (0 = empty flag)

- clock  in  1  sole clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of contents, same effect as reset
- in_valid  in  1  producer has a word on in_data
- in_ready  out  1  FIFO accepts a word this cycle
- in_data  in  WIDTH  write data
- in_almost_full  out  1  threshold flag, write side
- out_ready  in  1  consumer takes out_data this cycle
- out_valid  out  1  out_data holds the head word
- out_data  out  WIDTH  head word
- out_almost_empty  out  1  threshold flag, read side
- count  out  $clog2(DEPTH)+1  words held, 0..DEPTH

## Operation
- Push: in_valid && in_ready at a posedge. Pop: out_valid && out_ready at a posedge. No other condition moves data.
- Storage: DEPTH-entry registered-read RAM plus an output register. Total capacity is exactly DEPTH, output register included.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. An extra MSB, or an equivalent scheme, distinguishes full from empty.
- count includes every accepted word not yet popped, including words in the RAM-read and output-register pipeline.
  - Next count: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready is registered: 1 iff next count < DEPTH. in_valid has no effect when in_ready=0, and the word is not stored.
- in_almost_full is registered: (DEPTH - count) <= ALMOST_FULL.
- out_almost_empty is registered: count <= ALMOST_EMPTY.
- Both flags update on the same edge as count.
- out_valid/out_data form a first-word-fall-through stage:
  - The head word is presented without a request.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop is legal at any occupancy where each is individually allowed.
  - At count=DEPTH, in_ready=0, so a pop alone frees one slot and in_ready=1 from the next cycle.
- reset or flush has priority over push/pop in the same cycle. The simultaneous in_data word is discarded.
- Reset/flush values, on the next edge: count=0, in_ready=1, out_valid=0, in_almost_full=(DEPTH<=ALMOST_FULL), out_almost_empty=1, pointers=0. out_data is don't-care; RAM contents are not cleared.
- ALMOST_FULL >= DEPTH or ALMOST_EMPTY >= DEPTH is illegal and is checked by an elaboration-time error.

## Timing
- Write-to-read latency, starting from empty: a push at edge N gives out_valid=1 after edge N+2, with that word on out_data.
  - count=1 and out_almost_empty (ALMOST_EMPTY=0) deassert after edge N.
- Steady state: with out_ready held high and the FIFO non-empty, one pop per cycle with no bubbles.
- A pop at edge M presents the next word after edge M if it was written at or before edge M-2. Otherwise out_valid=0 until it arrives.
- Full throughput: continuous pushes and pops at 1 word/cycle indefinitely, with count constant.
- in_ready deasserts after the edge on which count reaches DEPTH. No combinational path from out_ready to in_ready.
- No combinational path from any input to any output.

## Test plan
- Reset, then 10 idle cycles: count=0, in_ready=1, out_valid=0, out_almost_empty=1, in_almost_full=0.
- Fill (WIDTH=8, DEPTH=16): push 0x00..0x0F back to back, out_ready=0.
  - in_ready=0 after the 16th push, count=16, in_almost_full=1.
  - A 17th in_valid with data 0xAA is ignored: count stays 16.
  - Drain: out_data reads 0x00..0x0F in order, no 0xAA, and ends with count=0, out_valid=0.
- Latency: a single push of 0x5A into empty at edge N gives out_valid=1 and out_data=0x5A after edge N+2. Pop at N+3 gives count=0.
- Thresholds (DEPTH=16, ALMOST_FULL=2, ALMOST_EMPTY=3):
  - in_almost_full rises on the edge count goes 13->14.
  - out_almost_empty falls on 3->4 and rises on 4->3.
- Concurrent traffic with wrap:
  - Random in_valid/out_ready at 50%, 10000 cycles, DEPTH=8.
  - Scoreboard shows order and data preserved, count equals pushes minus pops, pointers wrap many times.
  - When count=8 and out_ready=1, the pop happens that cycle and in_ready=1 on the next cycle.
- Flush mid-stream: 5 words held and in_valid=1 with 0x77 on the flush cycle.
  - Next cycle: count=0, out_valid=0, and 0x77 is never output.
  - A subsequent push of 0x11 appears after 2 edges.
